// File: rtl/nios2_debug_scan_cmd_slave.sv
// Debug scan slave: shifts a DR_WIDTH data register, captures per-instruction status words,
// and turns each update-DR into a held action request with ready/ack, overrun and watchdog.
module nios2_debug_scan_cmd_slave #(
  parameter int IR_WIDTH = 2,
  parameter int DR_WIDTH = 38,
  parameter int TIMEOUT  = 255,
  localparam int NUM_IR  = 2 ** IR_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [IR_WIDTH-1:0]        ir_in,
  input  logic                       vs_uir,
  input  logic                       vs_cdr,
  input  logic                       vs_sdr,
  input  logic                       vs_udr,
  input  logic                       tdi,
  input  logic [NUM_IR*DR_WIDTH-1:0] cap_data,
  input  logic                       act_ready,
  output logic                       tdo,
  output logic [DR_WIDTH-1:0]        jdo,
  output logic [NUM_IR-1:0]          take_action,
  output logic [NUM_IR-1:0]          take_no_action,
  output logic                       act_pending,
  output logic                       overrun,
  output logic                       timeout
);

  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WDOG_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t                state, state_n;
  logic [DR_WIDTH-1:0]   sr, sr_n, jdo_n;
  logic [IR_WIDTH-1:0]   ir_q, ir_n, act_code, code_n;
  logic                  act_flag, flag_n, overrun_n, timeout_n;
  logic [WW-1:0]         wdog, wdog_n;
  logic                  uir_en, cdr_en, sdr_en, udr_en;
  logic                  pending, expire, retire;
  logic [DR_WIDTH-1:0]   cap_word [NUM_IR];

  for (genvar k = 0; k < NUM_IR; k++) begin : g_cap
    assign cap_word[k] = cap_data[k*DR_WIDTH +: DR_WIDTH];
  end

  assign uir_en  = vs_uir;
  assign cdr_en  = vs_cdr & ~vs_uir;
  assign sdr_en  = vs_sdr & ~vs_uir & ~vs_cdr;
  assign udr_en  = vs_udr & ~vs_uir & ~vs_cdr & ~vs_sdr;
  assign pending = (state == PENDING);
  assign expire  = (TIMEOUT > 0) && pending && !act_ready && (wdog == WDOG_LAST);
  assign retire  = pending && (act_ready || expire);

  always_comb begin
    state_n   = state;
    sr_n      = sr;
    ir_n      = ir_q;
    jdo_n     = jdo;
    code_n    = act_code;
    flag_n    = act_flag;
    overrun_n = overrun;
    timeout_n = timeout;
    wdog_n    = wdog;

    if (uir_en) ir_n = ir_in;

    if (cdr_en) begin
      sr_n = cap_word[ir_q];
      if (ir_q == '0) begin
        sr_n[DR_WIDTH-1] = overrun;
        sr_n[DR_WIDTH-2] = timeout;
        overrun_n        = 1'b0;
        timeout_n        = 1'b0;
      end
    end

    if (sdr_en) sr_n = {tdi, sr[DR_WIDTH-1:1]};

    if (retire) state_n = IDLE;

    // A retiring cycle frees the slot, so a coincident update is taken without a gap.
    if (udr_en && (!pending || retire)) begin
      jdo_n   = sr;
      code_n  = ir_q;
      flag_n  = sr[DR_WIDTH-1];
      state_n = PENDING;
      wdog_n  = '0;
    end else begin
      if (udr_en) overrun_n = 1'b1;
      if (TIMEOUT > 0 && pending && !retire) wdog_n = wdog + 1'b1;
    end

    if (expire) timeout_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sr       <= '0;
      ir_q     <= '0;
      jdo      <= '0;
      act_code <= '0;
      act_flag <= 1'b0;
      overrun  <= 1'b0;
      timeout  <= 1'b0;
      wdog     <= '0;
    end else begin
      state    <= state_n;
      sr       <= sr_n;
      ir_q     <= ir_n;
      jdo      <= jdo_n;
      act_code <= code_n;
      act_flag <= flag_n;
      overrun  <= overrun_n;
      timeout  <= timeout_n;
      wdog     <= wdog_n;
    end
  end

  always_comb begin
    take_action    = '0;
    take_no_action = '0;
    if (pending) begin
      take_action[act_code]    = act_flag;
      take_no_action[act_code] = ~act_flag;
    end
  end

  assign act_pending = pending;
  assign tdo         = sr[0];

endmodule

// File: tb/tb_nios2_debug_scan_cmd_slave.sv
// Self-checking bench for nios2_debug_scan_cmd_slave (IR 2, DR 38, watchdog of 8 cycles).
module tb_nios2_debug_scan_cmd_slave;

  logic         clk = 1'b0;
  logic         reset, vs_uir, vs_cdr, vs_sdr, vs_udr, tdi, act_ready;
  logic [1:0]   ir_in;
  logic [151:0] cap_data;
  logic         tdo, act_pending, overrun, timeout;
  logic [37:0]  jdo;
  logic [3:0]   take_action, take_no_action;

  always #5 clk = ~clk;

  nios2_debug_scan_cmd_slave #(.IR_WIDTH(2), .DR_WIDTH(38), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .ir_in(ir_in), .vs_uir(vs_uir), .vs_cdr(vs_cdr),
    .vs_sdr(vs_sdr), .vs_udr(vs_udr), .tdi(tdi), .cap_data(cap_data),
    .act_ready(act_ready), .tdo(tdo), .jdo(jdo), .take_action(take_action),
    .take_no_action(take_no_action), .act_pending(act_pending),
    .overrun(overrun), .timeout(timeout)
  );

  typedef struct {
    logic [1:0]  ir;
    logic [37:0] word;
    int          hold;
    logic [3:0]  ta;
    logic [3:0]  tna;
  } vec_t;

  typedef struct {
    logic [3:0]  ta;
    logic [3:0]  tna;
    logic [37:0] jdo;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t cur;
  vec_t vecs[4];

  localparam logic [37:0] SLICE0 = 38'h15_0000_0055;
  localparam logic [37:0] SLICE1 = 38'h01_2345_6789;
  localparam logic [37:0] SLICE2 = 38'h2A_1234_5678;
  localparam logic [37:0] SLICE3 = 38'h3C_DEAD_BEEF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_uir(input logic [1:0] code);
    ir_in = code; vs_uir = 1'b1; tick(); vs_uir = 1'b0;
  endtask

  task automatic do_cdr();
    vs_cdr = 1'b1; tick(); vs_cdr = 1'b0;
  endtask

  task automatic do_udr();
    vs_udr = 1'b1; tick(); vs_udr = 1'b0;
  endtask

  task automatic do_ack();
    act_ready = 1'b1; tick(); act_ready = 1'b0;
  endtask

  task automatic shift_in(input logic [37:0] word);
    for (int i = 0; i < 38; i++) begin
      tdi = word[i]; vs_sdr = 1'b1; tick();
    end
    vs_sdr = 1'b0; tdi = 1'b0;
  endtask

  task automatic shift_out(input string name, input logic [37:0] exp);
    logic [37:0] got;
    for (int i = 0; i < 38; i++) begin
      got[i] = tdo;
      tdi = 1'b0; vs_sdr = 1'b1; tick();
    end
    vs_sdr = 1'b0;
    check(name, 64'(got), 64'(exp));
  endtask

  task automatic push_exp(input logic [3:0] ta, input logic [3:0] tna, input logic [37:0] j);
    exp_t e;
    e.ta = ta; e.tna = tna; e.jdo = j;
    sb.push_back(e);
  endtask

  task automatic sb_check(input string name);
    int n = 0;
    while (!act_pending && n < 4) begin tick(); n++; end
    check({name, "_pend"}, 64'(act_pending), 64'd1);
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      cur = sb.pop_front();
      check({name, "_ta"},  64'(take_action),    64'(cur.ta));
      check({name, "_tna"}, 64'(take_no_action), 64'(cur.tna));
      check({name, "_jdo"}, 64'(jdo),            64'(cur.jdo));
    end
  endtask

  initial begin
    logic [37:0] e;
    int          n;

    vecs[0] = '{ir: 2'd1, word: 38'h20_0000_00AB, hold: 3, ta: 4'b0010, tna: 4'b0000};
    vecs[1] = '{ir: 2'd3, word: 38'h1F_FFFF_FFFF, hold: 1, ta: 4'b0000, tna: 4'b1000};
    vecs[2] = '{ir: 2'd0, word: 38'h3F_FFFF_FFFF, hold: 0, ta: 4'b0001, tna: 4'b0000};
    vecs[3] = '{ir: 2'd2, word: 38'h25_5555_AAAA, hold: 6, ta: 4'b0100, tna: 4'b0000};

    reset = 1'b1; vs_uir = 0; vs_cdr = 0; vs_sdr = 0; vs_udr = 0; tdi = 0;
    act_ready = 0; ir_in = '0;
    cap_data = {SLICE3, SLICE2, SLICE1, SLICE0};
    tick(); tick();
    reset = 1'b0;
    check("reset_outs", 64'({tdo, take_action, take_no_action, act_pending, overrun, timeout}), 64'd0);
    check("reset_jdo", 64'(jdo), 64'd0);

    do_ack();
    check("idle_ack_ignored", 64'(act_pending), 64'd0);

    // capture slice 2 and shift it out LSB first; sr must end empty
    do_uir(2'd2);
    do_cdr();
    shift_out("cap_slice2", SLICE2);
    do_udr();
    push_exp(4'b0000, 4'b0100, 38'd0);
    sb_check("sr_empty");
    do_ack();

    // strobe priority: cdr beats a coincident sdr
    vs_cdr = 1'b1; vs_sdr = 1'b1; tdi = 1'b1; tick(); vs_cdr = 1'b0; vs_sdr = 1'b0; tdi = 1'b0;
    check("prio_cdr_over_sdr", 64'(tdo), 64'(SLICE2[0]));

    foreach (vecs[v]) begin
      do_uir(vecs[v].ir);
      shift_in(vecs[v].word);
      do_udr();
      push_exp(vecs[v].ta, vecs[v].tna, vecs[v].word);
      sb_check($sformatf("vec%0d", v));
      for (int h = 0; h < vecs[v].hold; h++) begin
        tick();
        check($sformatf("vec%0d_hold", v), 64'({act_pending, take_action, take_no_action, jdo}),
              64'({1'b1, cur.ta, cur.tna, cur.jdo}));
      end
      do_ack();
      check($sformatf("vec%0d_retire", v), 64'({act_pending, take_action, take_no_action}), 64'd0);
    end

    // overrun: second update while pending is dropped
    do_uir(2'd2);
    shift_in(38'h0A_BCDE_F012);
    do_udr();
    push_exp(4'b0000, 4'b0100, 38'h0A_BCDE_F012);
    sb_check("ovr_first");
    repeat (4) tick();
    do_udr();
    check("ovr_flag", 64'(overrun), 64'd1);
    check("ovr_hold", 64'({act_pending, take_no_action, jdo}), 64'({1'b1, 4'b0100, 38'h0A_BCDE_F012}));
    do_ack();
    do_uir(2'd0);
    do_cdr();
    check("ovr_cleared", 64'(overrun), 64'd0);
    e = SLICE0; e[37] = 1'b1; e[36] = 1'b0;
    shift_out("cap_ovr_status", e);

    // back-to-back: ack and new update in the same cycle
    do_uir(2'd1);
    shift_in(38'h20_0000_0001);
    do_udr();
    push_exp(4'b0010, 4'b0000, 38'h20_0000_0001);
    sb_check("b2b_first");
    do_uir(2'd2);
    do_cdr();
    act_ready = 1'b1; vs_udr = 1'b1; tick(); act_ready = 1'b0; vs_udr = 1'b0;
    push_exp(4'b0100, 4'b0000, SLICE2);
    check("b2b_no_ovr", 64'({act_pending, overrun}), 64'({1'b1, 1'b0}));
    sb_check("b2b_second");
    do_ack();

    // watchdog: exactly 8 pending cycles, then timeout sticky
    do_udr();
    n = 0;
    while (act_pending && n < 20) begin n++; tick(); end
    check("wdog_cycles", 64'(n), 64'd8);
    check("wdog_flag", 64'({timeout, take_action}), 64'({1'b1, 4'b0000}));
    do_uir(2'd0);
    do_cdr();
    check("wdog_cleared", 64'(timeout), 64'd0);
    e = SLICE0; e[37] = 1'b0; e[36] = 1'b1;
    shift_out("cap_to_status", e);

    // reset mid-pending with overrun set
    do_udr();
    do_udr();
    check("rst_pre_ovr", 64'({act_pending, overrun}), 64'({1'b1, 1'b1}));
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst_mid_outs", 64'({tdo, take_action, take_no_action, act_pending, overrun, timeout}), 64'd0);
    check("rst_mid_jdo", 64'(jdo), 64'd0);
    shift_in(38'h2B_0000_1111);
    do_udr();
    push_exp(4'b0001, 4'b0000, 38'h2B_0000_1111);
    sb_check("post_rst");
    do_ack();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
